alu_writeback_stage: RTL and testbench
======================================

// Module: alu_writeback_stage
// PURPOSE
//  Commit stage directly downstream of the ALU: accepts {c, flags, opcode, dest} per op, writes c to the register file,
//  keeps the processor status register (PSR), feeds PSR carry back to ALU carry_in, raises branch requests for BLT,
//  and traps on illegal opcodes. Opcode/flag encodings come from parameters.vh (CARRY_FLAG=0, LOW=1, FLAG=2, ZERO=3, NEG=4).
// PARAMETERS
//  DATA_W    16  datapath width (must match ALU c)
//  REG_AW     4  register-file address width
//  FLAG_W     5  ALU flag vector width
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  reset         in   1       synchronous, active-high
//  in_valid      in   1       ALU result valid
//  in_ready      out  1       stage can accept (= state==IDLE && !rf_busy)
//  in_result     in   DATA_W  ALU c
//  in_flags      in   FLAG_W  ALU flags
//  in_opcode     in   16      instruction word given to ALU
//  in_dest       in   REG_AW  destination register
//  rf_busy       in   1       register file cannot take a write this cycle
//  wr_en         out  1       register-file write strobe (1 cycle)
//  wr_addr       out  REG_AW  write address
//  wr_data       out  DATA_W  write data
//  psr           out  FLAG_W  processor status register
//  carry_out     out  1       to ALU carry_in
//  branch_req    out  1       1-cycle pulse: BLT taken
//  branch_off    out  4       branch offset (in_result[3:0] latched)
//  trap          out  1       sticky illegal-op indication
//  trap_opcode   out  16      opcode that caused trap
//  trap_ack      in   1       clears trap, returns to IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; wr_en=0, wr_addr=0, wr_data=0, psr=0, branch_req=0, branch_off=0, trap=0, trap_opcode=0.
//  - FSM IDLE -> COMMIT on in_valid&&in_ready (op latched); COMMIT -> IDLE next cycle (outputs valid during COMMIT, latency 1);
//    IDLE -> TRAP on accepted illegal op; TRAP -> IDLE only on trap_ack; in TRAP in_ready=0, no writes, PSR frozen.
//  - Legality decoded here from in_opcode (RTYPE ext ADD/OR/XOR/AND/SUB/CMP; SHIFTS ext LSHI L/R, ASHUI L/R, LSH, ASHU;
//    ADDI, SUBI, CMPI, SETI, BLT). in_flags[0] is NEVER treated as invalid-op (ALU reuses bit 0 for it; decode wins).
//  - Write-back: wr_en=1 in COMMIT for all legal ops except CMP, CMPI, BLT; wr_data=in_result, wr_addr=in_dest.
//  - PSR update mask (bits not listed hold value): ADD -> C,F,Z; SUB -> C,F; ADDI -> C; SUBI -> F; CMP/CMPI -> N,L,Z;
//    logic, shifts, SETI, BLT -> none. PSR written on the COMMIT edge.
//  - BLT: branch_req=1 in COMMIT iff in_result!=0; branch_off=in_result[3:0]; no register write.
//  - rf_busy=1 in IDLE holds in_ready low; the write is never dropped or duplicated.
//  - trap_ack in the same cycle TRAP is entered is ignored (needs >=1 cycle in TRAP).
//  - reset in any state (incl. COMMIT/TRAP) wins: pending write abandoned, outputs to reset values next edge.
//  - Back-to-back ops: max throughput 1 op / 2 cycles (IDLE/COMMIT alternation).
// CONFIGURATION
//  PSR_FORWARD_EN defined: carry_out = PSR C bit being written in the current COMMIT cycle when op updates C,
//    else psr[0]; dependent ADD may issue to ALU immediately.
//  PSR_FORWARD_EN undefined: carry_out = psr[0] (registered only); upstream must leave one bubble after C-updating ops.
// TESTING
//  1 RTYPE ADD, result 0x1234, flags 5'b00001, dest 3 -> COMMIT: wr_en=1, wr_addr=3, wr_data=0x1234; psr[0]=1, other bits 0.
//  2 CMP with in_flags 5'b11000 after psr=5'b00001 -> no wr_en; psr=5'b11001 (C kept).
//  3 BLT, in_result 0x0005 -> branch_req=1 one cycle, branch_off=5, wr_en=0; in_result 0 -> branch_req stays 0.
//  4 opcode with undefined major field, in_flags 5'b00001 -> trap=1, trap_opcode latched, psr unchanged, in_ready=0
//    until trap_ack; op then accepted normally.
//  5 rf_busy=1 for 3 cycles with in_valid=1 -> in_ready=0, no write; rf_busy drop -> exactly one write.
//  6 reset asserted during COMMIT of SUB -> psr=0, wr_en=0 next cycle; PSR_FORWARD_EN on/off: carry_out check vs psr[0].

Source files
------------

// File: rtl/alu_writeback_stage.sv
// Commit stage after the ALU: register write-back, PSR upkeep, BLT branch requests and illegal-op trap.
// Optional macro PSR_FORWARD_EN: carry_out forwards the carry being committed instead of waiting for the PSR.

package alu_writeback_pkg;
  // Flag bit positions and opcode fields mirror parameters.vh.
  localparam int CARRY_FLAG = 0;
  localparam int LOW        = 1;
  localparam int FLAG       = 2;
  localparam int ZERO       = 3;
  localparam int NEG        = 4;

  localparam logic [3:0] MAJ_RTYPE  = 4'h0;
  localparam logic [3:0] MAJ_ADDI   = 4'h5;
  localparam logic [3:0] MAJ_SHIFTS = 4'h8;
  localparam logic [3:0] MAJ_SUBI   = 4'h9;
  localparam logic [3:0] MAJ_CMPI   = 4'hB;
  localparam logic [3:0] MAJ_BLT    = 4'hC;
  localparam logic [3:0] MAJ_SETI   = 4'hD;

  localparam logic [3:0] EXT_AND = 4'h1;
  localparam logic [3:0] EXT_OR  = 4'h2;
  localparam logic [3:0] EXT_XOR = 4'h3;
  localparam logic [3:0] EXT_ADD = 4'h5;
  localparam logic [3:0] EXT_SUB = 4'h9;
  localparam logic [3:0] EXT_CMP = 4'hB;

  localparam logic [3:0] EXT_LSHI_L  = 4'h0;
  localparam logic [3:0] EXT_LSHI_R  = 4'h1;
  localparam logic [3:0] EXT_ASHUI_L = 4'h2;
  localparam logic [3:0] EXT_ASHUI_R = 4'h3;
  localparam logic [3:0] EXT_LSH     = 4'h4;
  localparam logic [3:0] EXT_ASHU    = 4'h6;

  // Commit behaviour groups: each class fixes the write enable and the PSR update mask.
  typedef enum logic [2:0] {
    CLS_ADD, CLS_SUB, CLS_ADDI, CLS_SUBI, CLS_CMP, CLS_PLAIN, CLS_BLT, CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e decode_op(input logic [3:0] major, input logic [3:0] ext);
    op_class_e cls;
    cls = CLS_ILLEGAL;
    case (major)
      MAJ_RTYPE: begin
        case (ext)
          EXT_AND, EXT_OR, EXT_XOR: cls = CLS_PLAIN;
          EXT_ADD:                  cls = CLS_ADD;
          EXT_SUB:                  cls = CLS_SUB;
          EXT_CMP:                  cls = CLS_CMP;
          default:                  cls = CLS_ILLEGAL;
        endcase
      end
      MAJ_SHIFTS: begin
        case (ext)
          EXT_LSHI_L, EXT_LSHI_R, EXT_ASHUI_L, EXT_ASHUI_R, EXT_LSH, EXT_ASHU: cls = CLS_PLAIN;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      MAJ_ADDI: cls = CLS_ADDI;
      MAJ_SUBI: cls = CLS_SUBI;
      MAJ_CMPI: cls = CLS_CMP;
      MAJ_SETI: cls = CLS_PLAIN;
      MAJ_BLT:  cls = CLS_BLT;
      default:  cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction
endpackage

module alu_writeback_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int FLAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [FLAG_W-1:0] in_flags,
  input  logic [15:0]       in_opcode,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              rf_busy,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [FLAG_W-1:0] psr,
  output logic              carry_out,
  output logic              branch_req,
  output logic [3:0]        branch_off,
  output logic              trap,
  output logic [15:0]       trap_opcode,
  input  logic              trap_ack
);
  import alu_writeback_pkg::*;

  typedef enum logic [1:0] {IDLE, COMMIT, TRAP} state_e;

  state_e            state_q, state_d;
  op_class_e         in_class, cls_q;
  logic              accept, in_legal;
  logic [FLAG_W-1:0] flags_q, psr_mask;

  // in_flags[0] doubles as an ALU invalid-op hint; legality comes from the opcode alone.
  assign in_ready = (state_q == IDLE) && !rf_busy;
  assign accept   = in_valid && in_ready;
  assign in_class = decode_op(in_opcode[15:12], in_opcode[7:4]);
  assign in_legal = (in_class != CLS_ILLEGAL);

  always_comb begin
    // NOTE: default assigned first so every path drives state_d; a missing branch would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_legal ? COMMIT : TRAP;
      COMMIT:  state_d = IDLE;
      TRAP:    if (trap_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values whatever the block order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    psr_mask = '0;
    case (cls_q)
      CLS_ADD: begin
        psr_mask[CARRY_FLAG] = 1'b1;
        psr_mask[FLAG]       = 1'b1;
        psr_mask[ZERO]       = 1'b1;
      end
      CLS_SUB: begin
        psr_mask[CARRY_FLAG] = 1'b1;
        psr_mask[FLAG]       = 1'b1;
      end
      CLS_ADDI: psr_mask[CARRY_FLAG] = 1'b1;
      CLS_SUBI: psr_mask[FLAG]       = 1'b1;
      CLS_CMP: begin
        psr_mask[NEG]  = 1'b1;
        psr_mask[LOW]  = 1'b1;
        psr_mask[ZERO] = 1'b1;
      end
      default: psr_mask = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      psr         <= '0;
      branch_req  <= 1'b0;
      branch_off  <= '0;
      trap        <= 1'b0;
      trap_opcode <= '0;
      cls_q       <= CLS_PLAIN;
      flags_q     <= '0;
    end else begin
      wr_en      <= 1'b0;
      branch_req <= 1'b0;
      if (accept && in_legal) begin
        cls_q   <= in_class;
        flags_q <= in_flags;
        wr_addr <= in_dest;
        wr_data <= in_result;
        wr_en   <= !(in_class inside {CLS_CMP, CLS_BLT});
        if (in_class == CLS_BLT) begin
          branch_req <= (in_result != '0);
          branch_off <= in_result[3:0];
        end
      end
      if (accept && !in_legal) begin
        trap        <= 1'b1;
        trap_opcode <= in_opcode;
      end
      // PSR lands on the edge that closes COMMIT, so the committing op sees the old PSR.
      if (state_q == COMMIT) psr <= (psr & ~psr_mask) | (flags_q & psr_mask);
      if (state_q == TRAP && trap_ack) trap <= 1'b0;
    end
  end

`ifdef PSR_FORWARD_EN
  assign carry_out = (state_q == COMMIT && psr_mask[CARRY_FLAG]) ? flags_q[CARRY_FLAG] : psr[CARRY_FLAG];
`else
  assign carry_out = psr[CARRY_FLAG];
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: driver predicts each commit from an opcode-table model,
// an independent monitor compares DUT outputs cycle by cycle.

module tb_alu_writeback_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] in_result;
  logic [4:0]  in_flags;
  logic [15:0] in_opcode;
  logic [3:0]  in_dest;
  logic        rf_busy;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [4:0]  psr;
  logic        carry_out;
  logic        branch_req;
  logic [3:0]  branch_off;
  logic        trap;
  logic [15:0] trap_opcode;
  logic        trap_ack;

  alu_writeback_stage #(.DATA_W(16), .REG_AW(4), .FLAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_opcode(in_opcode), .in_dest(in_dest),
    .rf_busy(rf_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .psr(psr),
    .carry_out(carry_out), .branch_req(branch_req), .branch_off(branch_off),
    .trap(trap), .trap_opcode(trap_opcode), .trap_ack(trap_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Flag masks by name: C=bit0, L=bit1, F=bit2, Z=bit3, N=bit4.
  localparam logic [4:0] M_C = 5'b00001, M_L = 5'b00010, M_F = 5'b00100, M_Z = 5'b01000, M_N = 5'b10000;

  typedef struct {
    int         cyc;
    bit         illegal;
    bit         wr;
    bit         br;
    logic [3:0] addr;
    logic [15:0] data;
    logic [3:0] off;
    logic [4:0] psr_after;
    bit         upd_c;
    bit         new_c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_r;

  int         n_total = 0, n_pass = 0;
  bit         mon_en = 0;
  bit         trapped = 0;
  int         next_free = 0;
  logic [4:0] model_psr = '0;
  logic [4:0] vis_psr = '0;
  bit         psr_pend = 0;
  logic [4:0] psr_next = '0;
  bit         exp_trap = 0;
  logic [15:0] exp_trap_op = '0;
  logic       exp_carry;

  logic [3:0] rtype_ext [6] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB};
  logic [3:0] shift_ext [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6};
  logic [3:0] imm_maj   [5] = '{4'h5, 4'h9, 4'hB, 4'hD, 4'hC};
  logic [3:0] bad_maj   [9] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'hA, 4'hE, 4'hF};
  logic [3:0] bad_rext  [10] = '{4'h0, 4'h4, 4'h6, 4'h7, 4'h8, 4'hA, 4'hC, 4'hD, 4'hE, 4'hF};
  logic [3:0] bad_sext  [10] = '{4'h5, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  // Reference: instruction-set table giving legality, whether a register is written, and which PSR flags change.
  function automatic void ref_decode(input logic [15:0] op, output bit legal, output bit writes,
                                     output logic [4:0] mask);
    legal = 1; writes = 1; mask = '0;
    case (op[15:12])
      4'h0: case (op[7:4])
              4'h1, 4'h2, 4'h3: ;
              4'h5: mask = M_C | M_F | M_Z;
              4'h9: mask = M_C | M_F;
              4'hB: begin mask = M_N | M_L | M_Z; writes = 0; end
              default: legal = 0;
            endcase
      4'h8: if (!(op[7:4] inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6})) legal = 0;
      4'h5: mask = M_C;
      4'h9: mask = M_F;
      4'hB: begin mask = M_N | M_L | M_Z; writes = 0; end
      4'hD: ;
      4'hC: writes = 0;
      default: legal = 0;
    endcase
    if (!legal) writes = 0;
  endfunction

  function automatic logic [15:0] rand_op(input bit want_illegal);
    logic [3:0] maj, ext;
    int k;
    ext = 4'($urandom);
    if (!want_illegal) begin
      k = $urandom_range(0, 5);
      if (k < 2) begin maj = 4'h0; ext = rtype_ext[$urandom_range(0, 5)]; end
      else if (k == 2) begin maj = 4'h8; ext = shift_ext[$urandom_range(0, 5)]; end
      else maj = imm_maj[$urandom_range(0, 4)];
    end else begin
      k = $urandom_range(0, 2);
      if (k == 0) maj = bad_maj[$urandom_range(0, 8)];
      else if (k == 1) begin maj = 4'h0; ext = bad_rext[$urandom_range(0, 9)]; end
      else begin maj = 4'h8; ext = bad_sext[$urandom_range(0, 9)]; end
    end
    return {maj, 4'($urandom), ext, 4'($urandom)};
  endfunction

  task automatic issue(input logic [15:0] op, input logic [15:0] res, input logic [4:0] fl,
                       input logic [3:0] dst, input int busy, input bit ack_same, input bit reset_after);
    bit legal, writes, ok;
    logic [4:0] mask;
    exp_t r;
    int tries, c, left;
    ref_decode(op, legal, writes, mask);
    left = busy;
    ok = 0;
    @(negedge clk);
    in_valid = 1; in_opcode = op; in_result = res; in_flags = fl; in_dest = dst; trap_ack = ack_same;
    for (tries = 0; tries < 60; tries++) begin
      rf_busy = (left > 0);
      if (left > 0) left--;
      #1;
      if (!trapped && cyc >= next_free && !rf_busy) begin
        check("in_ready_high", in_ready, 1);
        ok = 1;
        break;
      end
      check("in_ready_low", in_ready, 0);
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    c = cyc;
    r.cyc = c + 1; r.illegal = !legal; r.wr = writes; r.addr = dst; r.data = res;
    r.br = legal && (op[15:12] == 4'hC) && (res != 0); r.off = res[3:0];
    r.upd_c = legal && mask[0]; r.new_c = fl[0];
    if (legal) begin
      model_psr = reset_after ? 5'b0 : ((model_psr & ~mask) | (fl & mask));
      next_free = c + 2;
    end
    r.psr_after = model_psr;
    sb.push_back(r);
    @(posedge clk); #1;
    rf_busy = 0;
    if (!legal) begin exp_trap = 1; exp_trap_op = op; trapped = 1; end
  endtask

  task automatic recover_trap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      trap_ack = 0; in_valid = 1; in_opcode = 16'h0050;
      #1 check("in_ready_trap", in_ready, 0);
    end
    @(negedge clk);
    trap_ack = 1; in_valid = 0;
    @(posedge clk); #1;
    exp_trap = 0; trapped = 0; next_free = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 0; trap_ack = 0; rf_busy = 1'($urandom);
    end
  endtask

  // Monitor: pops a record on its commit cycle, otherwise expects a silent stage.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (psr_pend) begin vis_psr = psr_next; psr_pend = 0; end
        exp_carry = vis_psr[0];
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
          check("commit_missed", 0, 1);
          void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          mon_r = sb.pop_front();
          check("wr_en", wr_en, mon_r.wr);
          if (mon_r.wr) begin
            check("wr_addr", wr_addr, mon_r.addr);
            check("wr_data", wr_data, mon_r.data);
          end
          check("branch_req", branch_req, mon_r.br);
          if (mon_r.br) check("branch_off", branch_off, mon_r.off);
`ifdef PSR_FORWARD_EN
          if (mon_r.upd_c) exp_carry = mon_r.new_c;
`endif
          if (!mon_r.illegal) begin psr_pend = 1; psr_next = mon_r.psr_after; end
        end else begin
          check("idle_no_strobe", {wr_en, branch_req}, 2'b00);
        end
        check("psr", psr, vis_psr);
        check("carry_out", carry_out, exp_carry);
        check("trap", trap, exp_trap);
        if (exp_trap) check("trap_opcode", trap_opcode, exp_trap_op);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ill;
    reset = 1; in_valid = 0; in_result = '0; in_flags = '0; in_opcode = '0; in_dest = '0;
    rf_busy = 0; trap_ack = 0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_psr", psr, 0);
    check("rst_branch_req", branch_req, 0);
    check("rst_branch_off", branch_off, 0);
    check("rst_trap", trap, 0);
    check("rst_trap_opcode", trap_opcode, 0);
    check("rst_carry_out", carry_out, 0);
    reset = 0;
    #1 mon_en = 1; next_free = cyc;

    // ADD commit, then CMP keeping C, then BLT taken / not taken
    issue(16'h0053, 16'h1234, 5'b00001, 4'd3, 0, 0, 0);
    issue(16'h02B1, 16'h7777, 5'b11000, 4'd6, 0, 0, 0);
    issue(16'hC000, 16'h0005, 5'b00000, 4'd1, 0, 0, 0);
    issue(16'hC000, 16'h0000, 5'b11111, 4'd2, 0, 0, 0);
    // undefined major with flags[0]=1, ack offered on the entry cycle, then recovery
    issue(16'hF123, 16'hABCD, 5'b00001, 4'd4, 0, 1, 0);
    recover_trap(3);
    issue(16'h0157, 16'h00FF, 5'b00111, 4'd9, 0, 0, 0);
    // register file busy for three cycles while the op waits
    idle(1);
    issue(16'h5A00, 16'h4321, 5'b01111, 4'd7, 3, 0, 0);

    for (int i = 0; i < 200; i++) begin
      ill = ($urandom_range(0, 9) == 0);
      issue(rand_op(ill), ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), 5'($urandom),
            4'($urandom), $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0, 0, 0);
      if (ill) recover_trap($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    // reset lands while a SUB is in COMMIT
    issue(16'h0EB0, 16'h0001, 5'b11010, 4'd0, 0, 0, 0);
    issue(16'h0090, 16'h5555, 5'b00101, 4'd5, 0, 0, 1);
    @(negedge clk); reset = 1; in_valid = 0;
    @(negedge clk); reset = 0;
    #1 next_free = cyc;
    issue(16'h0053, 16'h0042, 5'b00001, 4'd8, 0, 0, 0);
    idle(1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
